// File: rtl/otp_ctrl.sv
// OTP macro access controller: sequences VPP/CS/PROG/READ pin timing for one
// program or read access per host request, with all pin outputs registered.
// Optional build macro OTP_CTRL_VERIFY_EN: every program access is followed
// by a read-back of the same address; err reports a data mismatch.
module otp_ctrl #(
  parameter int unsigned T_GAP      = 64,
  parameter int unsigned T_CS_SETUP = 320,
  parameter int unsigned T_PROG     = 15000,
  parameter int unsigned T_READ     = 120
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req,
  input  logic       we,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       err,
  output logic       VPP,
  output logic       CS,
  output logic       PROG,
  output logic       READ,
  output logic [6:0] ADR,
  output logic [7:0] DIN,
  input  logic [7:0] DO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VPP_ON,
    S_CS_SU,
    S_PULSE,
    S_PHOLD,
    S_CS_OFF,
    S_VPP_OFF,
    S_DONE
  } state_t;

  localparam logic [15:0] LD_GAP  = 16'(T_GAP - 1);
  localparam logic [15:0] LD_CSSU = 16'(T_CS_SETUP - 1);
  localparam logic [15:0] LD_PROG = 16'(T_PROG - 1);
  localparam logic [15:0] LD_READ = 16'(T_READ - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        we_q;
  logic        pgm_phase;

`ifdef OTP_CTRL_VERIFY_EN
  logic        verify_q;

  // Second pass of a program access is a read-back, so the pulse becomes READ.
  assign pgm_phase = we_q & ~verify_q;
`else
  assign pgm_phase = we_q;
  assign err       = 1'b0;
`endif

  // Access sequencer: state, duration counter, latched request and registered pins.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      we_q  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      rdata <= '0;
      VPP   <= 1'b0;
      CS    <= 1'b0;
      PROG  <= 1'b0;
      READ  <= 1'b0;
      ADR   <= '0;
      DIN   <= '0;
`ifdef OTP_CTRL_VERIFY_EN
      verify_q <= 1'b0;
      err      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            state <= S_VPP_ON;
            cnt   <= LD_GAP;
            we_q  <= we;
            ADR   <= addr;
            DIN   <= wdata;
            VPP   <= 1'b1;
            busy  <= 1'b1;
`ifdef OTP_CTRL_VERIFY_EN
            verify_q <= 1'b0;
`endif
          end
        end
        S_VPP_ON: begin
          if (cnt == '0) begin
            state <= S_CS_SU;
            cnt   <= LD_CSSU;
            CS    <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_CS_SU: begin
          if (cnt == '0) begin
            state <= S_PULSE;
            cnt   <= pgm_phase ? LD_PROG : LD_READ;
            PROG  <= pgm_phase;
            READ  <= ~pgm_phase;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_PULSE: begin
          if (cnt == '0) begin
            state <= S_PHOLD;
            cnt   <= LD_GAP;
            PROG  <= 1'b0;
            READ  <= 1'b0;
            // READ is still high on this cycle, so DO is valid here.
            if (!pgm_phase) begin
              rdata <= DO;
`ifdef OTP_CTRL_VERIFY_EN
              if (we_q) begin
                err <= (DO != DIN);
              end
`endif
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_PHOLD: begin
          if (cnt == '0) begin
            state <= S_CS_OFF;
            cnt   <= LD_GAP;
            CS    <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_CS_OFF: begin
          if (cnt == '0) begin
            state <= S_VPP_OFF;
            cnt   <= LD_GAP;
            VPP   <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_VPP_OFF: begin
          if (cnt == '0) begin
`ifdef OTP_CTRL_VERIFY_EN
            if (we_q && !verify_q) begin
              verify_q <= 1'b1;
              state    <= S_VPP_ON;
              cnt      <= LD_GAP;
              VPP      <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
`else
            state <= S_DONE;
            done  <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otp_ctrl.sv
// Self-checking bench for otp_ctrl: table-driven reads, hand sequences for
// program, held req, mid-pulse reset and back-to-back access, with a pin
// timing monitor, a simple OTP array model and a done-pulse scoreboard.
module tb_otp_ctrl;

  localparam int unsigned TG  = 64;
  localparam int unsigned TCS = 320;
  localparam int unsigned TP  = 15000;
  localparam int unsigned TR  = 120;
  localparam int unsigned READ_BUSY = 4*TG + TCS + TR + 1;
`ifdef OTP_CTRL_VERIFY_EN
  localparam int unsigned PROG_BUSY = 4*TG + TCS + TP + 4*TG + TCS + TR + 1;
  localparam int unsigned PROG_RD_PULSES = 1;
`else
  localparam int unsigned PROG_BUSY = 4*TG + TCS + TP + 1;
  localparam int unsigned PROG_RD_PULSES = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, err, VPP, CS, PROG, READ;
  logic [7:0] rdata, DIN, DO;
  logic [6:0] ADR;

  logic [7:0] mem [128] = '{default: 8'h00};
  logic       do_force = 1'b0;
  logic [7:0] do_force_val = '0;

  assign DO = do_force ? do_force_val : mem[ADR];

  always #5 CLK = ~CLK;

  otp_ctrl #(.T_GAP(TG), .T_CS_SETUP(TCS), .T_PROG(TP), .T_READ(TR)) dut (
    .CLK(CLK), .RST(RST), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .err(err),
    .VPP(VPP), .CS(CS), .PROG(PROG), .READ(READ), .ADR(ADR), .DIN(DIN), .DO(DO)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [7:0] r;
    logic       e;
  } exp_t;
  exp_t sb_q[$];
  exp_t sb_x;

  typedef struct {
    logic       w;
    logic [6:0] a;
    logic [7:0] d;
    logic [7:0] dov;
    logic [7:0] exp_r;
    logic       exp_e;
  } vec_t;
  vec_t vt[5];

  // Pin monitor: segment lengths, PROG/READ exclusion, ADR stability under CS,
  // OTP array write on PROG fall, and scoreboard check on every done pulse.
  logic [3:0]  pins_now;
  logic [3:0]  pins_prev = '0;
  logic [6:0]  adr_p = '0;
  int unsigned seg = 0;
  int unsigned rd_pulses = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      pins_prev = '0;
      seg = 0;
    end else begin
      pins_now = {VPP, CS, PROG, READ};
      if (pins_now != pins_prev) begin
        case (pins_prev)
          4'b1000: check("vpp_gap_len", seg, TG);
          4'b1100: begin
            if (pins_now[1] | pins_now[0]) check("cs_setup_len", seg, TCS);
            else check("phold_len", seg, TG);
          end
          4'b1110: check("prog_width", seg, TP);
          4'b1101: check("read_width", seg, TR);
          default: ;
        endcase
        check("prog_read_exclusive", {31'd0, pins_now[1] & pins_now[0]}, 0);
        if (pins_now[0] && !pins_prev[0]) rd_pulses++;
        if (pins_prev[1] && !pins_now[1]) mem[ADR] = DIN;
        seg = 1;
      end else begin
        seg++;
      end
      if (pins_prev[2] && CS && ADR !== adr_p) check("adr_stable_under_cs", ADR, adr_p);
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          sb_x = sb_q.pop_front();
          check("rdata_at_done", rdata, sb_x.r);
          check("err_at_done", err, sb_x.e);
        end
      end
      pins_prev = pins_now;
      adr_p = ADR;
    end
  end

  // One complete access started at a negedge; returns at the first negedge with busy low.
  task automatic access(input logic w, input logic [6:0] a, input logic [7:0] d,
                        input logic [7:0] exp_r, input logic exp_e,
                        output int unsigned bcyc);
    exp_t x;
    logic stable;
    x.r = exp_r;
    x.e = exp_e;
    sb_q.push_back(x);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge CLK);
    req = 1'b0;
    bcyc = 0;
    stable = 1'b1;
    for (int i = 0; i < 40000 && busy; i++) begin
      bcyc++;
      if (ADR !== a || DIN !== d) stable = 1'b0;
      @(negedge CLK);
    end
    check("busy_timeout", {31'd0, busy}, 0);
    check("adr_din_hold", {31'd0, stable}, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned bc;
    int unsigned rp0;
    logic        ok;
    vt[0] = '{1'b0, 7'h15, 8'h00, 8'hA5, 8'hA5, 1'b0};
    vt[1] = '{1'b0, 7'h00, 8'h12, 8'h00, 8'h00, 1'b0};
    vt[2] = '{1'b0, 7'h7F, 8'hFF, 8'hFF, 8'hFF, 1'b0};
    vt[3] = '{1'b0, 7'h2A, 8'hC3, 8'h5A, 8'h5A, 1'b0};
    vt[4] = '{1'b0, 7'h01, 8'h00, 8'h80, 8'h80, 1'b0};

    #22;
    check("reset_outputs", {VPP, CS, PROG, READ, busy, done, err, ADR, DIN, rdata}, 0);
    @(negedge CLK);
    RST = 1'b1;

    // Table-driven reads with forced DO
    do_force = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_force_val = vt[i].dov;
      access(vt[i].w, vt[i].a, vt[i].d, vt[i].exp_r, vt[i].exp_e, bc);
      check("read_busy_cycles", bc, READ_BUSY);
    end

    // req held through the access with a changed address: ignored
    do_force_val = 8'h3E;
    sb_q.push_back('{8'h3E, 1'b0});
    req = 1'b1; we = 1'b0; addr = 7'h15; wdata = 8'h00;
    @(negedge CLK);
    addr = 7'h7F;
    ok = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (ADR !== 7'h15) ok = 1'b0;
      @(negedge CLK);
    end
    check("held_req_done_seen", {31'd0, done}, 1);
    req = 1'b0;
    check("held_req_adr_stable", {31'd0, ok}, 1);
    ok = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (busy) ok = 1'b0;
    end
    check("held_req_not_queued", {31'd0, ok}, 1);

    // Program through the array model
    do_force = 1'b0;
    rp0 = rd_pulses;
`ifdef OTP_CTRL_VERIFY_EN
    access(1'b1, 7'h03, 8'h3C, 8'h3C, 1'b0, bc);
`else
    access(1'b1, 7'h03, 8'h3C, 8'h3E, 1'b0, bc);
`endif
    check("prog_busy_cycles", bc, PROG_BUSY);
    check("prog_read_pulses", rd_pulses - rp0, PROG_RD_PULSES);
    check("otp_mem_written", mem[7'h03], 8'h3C);

`ifdef OTP_CTRL_VERIFY_EN
    // Verify mismatch and match
    do_force = 1'b1;
    do_force_val = 8'h54;
    access(1'b1, 7'h20, 8'h55, 8'h54, 1'b1, bc);
    do_force_val = 8'h55;
    access(1'b1, 7'h20, 8'h55, 8'h55, 1'b0, bc);
    do_force = 1'b0;
`endif

    // Reset during the PROG pulse
    req = 1'b1; we = 1'b1; addr = 7'h44; wdata = 8'h11;
    @(negedge CLK);
    req = 1'b0;
    for (int i = 0; i < 2000 && !PROG; i++) @(negedge CLK);
    check("prog_pulse_seen", {31'd0, PROG}, 1);
    repeat (5000) @(negedge CLK);
    #2 RST = 1'b0;
    #1 check("mid_reset_outputs", {VPP, CS, PROG, READ, busy, done, err, ADR, DIN, rdata}, 0);
    repeat (5) @(negedge CLK);
    check("aborted_prog_no_write", mem[7'h44], 8'h00);
    RST = 1'b1;
    do_force = 1'b1;
    do_force_val = 8'h77;
    access(1'b0, 7'h44, 8'h00, 8'h77, 1'b0, bc);
    check("post_reset_read_busy", bc, READ_BUSY);
    do_force = 1'b0;

    // Back-to-back program then read of the same location
`ifdef OTP_CTRL_VERIFY_EN
    access(1'b1, 7'h10, 8'h9A, 8'h9A, 1'b0, bc);
`else
    access(1'b1, 7'h10, 8'h9A, 8'h77, 1'b0, bc);
`endif
    access(1'b0, 7'h10, 8'h00, 8'h9A, 1'b0, bc);
    check("b2b_read_busy", bc, READ_BUSY);

    repeat (5) @(negedge CLK);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/otp_ctrl.md
OTP_CTRL -- requirements
Module: otp_ctrl

Interface
REQ-001 SHALL have parameter T_GAP, default 64: CLK cycles of each pin setup/hold gap (legal 50..1000).
REQ-002 SHALL have parameter T_CS_SETUP, default 320: CLK cycles from CS rise to PROG/READ rise (legal 300..1000).
REQ-003 SHALL have parameter T_PROG, default 15000: PROG high width in CLK cycles (legal 10000..20000).
REQ-004 SHALL have parameter T_READ, default 120: READ high width in CLK cycles (legal 100..1000).
REQ-005 SHALL have ports:
 CLK  in  1  clock
 RST  in  1  reset, asynchronous, active-low
 req  in  1  host access request, sampled when busy=0
 we  in  1  1=program, 0=read; sampled with req
 addr  in  7  host address; sampled with req
 wdata  in  8  program data; sampled with req
 busy  out  1  access in progress
 done  out  1  one-cycle completion pulse
 rdata  out  8  read data, held until next read completes
 err  out  1  verify mismatch flag (macro-dependent)
 VPP  out  1  OTP programming supply enable
 CS  out  1  OTP chip select
 PROG  out  1  OTP program strobe
 READ  out  1  OTP read strobe
 ADR  out  7  OTP address
 DIN  out  8  OTP write data
 DO  in  8  OTP read data

Function
REQ-006 SHALL accept req only in IDLE; req while busy=1 SHALL be ignored (not queued).
REQ-007 SHALL on accept latch we/addr/wdata, drive ADR/DIN from latches and hold them constant until return to IDLE.
REQ-008 SHALL sequence states IDLE -> VPP_ON -> CS_SU -> PULSE -> PHOLD -> CS_OFF -> VPP_OFF -> DONE -> IDLE.
REQ-009 SHALL hold each of VPP_ON, PHOLD, CS_OFF, VPP_OFF exactly T_GAP cycles; CS_SU exactly T_CS_SETUP; PULSE exactly T_PROG (we=1) or T_READ (we=0).
REQ-010 SHALL drive VPP=1 from VPP_ON through CS_OFF; CS=1 in CS_SU, PULSE, PHOLD; PROG or READ=1 only in PULSE; never PROG and READ together.
REQ-011 SHALL use one 16-bit down-counter, loaded on state entry with (duration-1) and transitioning when it reads 0.
REQ-012 SHALL for reads capture DO into rdata on the last PULSE cycle (READ still high).
REQ-013 SHALL assert busy=1 in every state except IDLE; done=1 for exactly the single DONE cycle.
REQ-014 SHALL register all pin outputs (no combinational glitches on VPP/CS/PROG/READ/ADR/DIN).
REQ-015 SHALL keep ADR unchanged whenever CS=1.
REQ-016 SHALL accept a new req in the cycle after DONE (back-to-back accesses separated by IDLE cycle).

Reset
REQ-017 SHALL on RST low immediately force VPP, CS, PROG, READ, busy, done, err=0, ADR=0, DIN=0, rdata=0, counter=0, state=IDLE.
REQ-018 SHALL on reset mid-access abort without completing it; no done pulse; rdata stays 0.
REQ-019 SHALL resume operation on the first CLK rising edge after RST deasserts.

Configuration
REQ-020 SHALL support macro OTP_CTRL_VERIFY_EN.
REQ-021 With OTP_CTRL_VERIFY_EN defined, a program access SHALL after VPP_OFF run a full read sequence (VPP_ON..VPP_OFF, T_READ pulse) on the same address, load rdata, and set err=1 if rdata!=wdata else err=0, then DONE; busy held throughout.
REQ-022 Without OTP_CTRL_VERIFY_EN, program access SHALL go VPP_OFF -> DONE directly; err SHALL be constant 0; rdata unchanged by programs.
REQ-023 Read accesses SHALL never modify err.

Verification
REQ-024 Read: req=1, we=0, addr=7'h15, DO=8'hA5 -> READ high exactly 120 cycles, CS rises 64 cycles after VPP, rdata=8'hA5, one done pulse; total busy = 4*64+320+120+1 cycles.
REQ-025 Program: we=1, addr=7'h03, wdata=8'h3C -> PROG high exactly 15000 cycles, DIN=8'h3C and ADR=7'h03 stable whole access, READ never high (macro off).
REQ-026 Verify (macro on): program wdata=8'h55 with DO returning 8'h54 -> err=1 at done; repeat with DO=8'h55 -> err=0.
REQ-027 Reset at cycle 5000 of PROG pulse -> all pins 0 same edge of RST fall, no done, next req completes normally.
REQ-028 req held high during busy with changed addr=7'h7F -> ignored; ADR unchanged; only one done per accepted req.
REQ-029 Connect to OTP model: back-to-back program 7'h10<-8'h9A then read 7'h10 -> rdata=8'h9A, model reports no timing error.
